// File: rtl/rmii_pkg.sv
// rmii_pkg: shared types and limits for the UDP payload framing path
package rmii_pkg;
  typedef logic [11:0] len_t;
  localparam int MAX_UDP_PAYLOAD = 1472;
  typedef enum logic {WR_FILL, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_state_t;
endpackage

// File: rtl/sync_ram_1r1w.sv
// sync_ram_1r1w: simple dual-port RAM with registered read data
module sync_ram_1r1w #(
  parameter int DEPTH = 2048,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/axis_len_framer.sv
// axis_len_framer: store-and-forward byte framer that carries each frame's length on tuser
module axis_len_framer
  import rmii_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int MAX_LEN = MAX_UDP_PAYLOAD,
  parameter int LEN_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [7:0]                   m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output len_t                         m_axis_tuser,
  input  logic                         m_axis_tready,
  output logic                         drop_pulse,
  output logic [$clog2(LEN_DEPTH):0]   frames_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);
  typedef logic [AW:0] ptr_t;
  typedef logic [LW:0] lptr_t;
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  ptr_t wp, wp_c, rp;
  len_t cnt, rem, head_len;
  lptr_t lf_wp, lf_rp;
  len_t lf_mem [LEN_DEPTH];
  logic [LW-1:0] head_idx;
  logic live, s_acc, m_acc, discard, wr_en, push, drop, pop, more, load, rd_en;
  logic buf_full, lf_full, lf_empty;
  assign frames_pending = lf_wp - lf_rp;
  assign lf_full = frames_pending == lptr_t'(LEN_DEPTH);
  assign lf_empty = frames_pending == '0;
  assign buf_full = (wp - rp) == ptr_t'(DEPTH);
  assign s_axis_tready = live && (wr_state == WR_DROP || (!buf_full && !lf_full));
  assign s_acc = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = rd_state == RD_SEND;
  assign m_axis_tlast = m_axis_tvalid && rem == len_t'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_state <= WR_FILL;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  // Once MAX_LEN bytes are held, the next byte is never written: it either ends the frame (drop now) or starts a drop run.
  always_comb begin
    discard = wr_state == WR_DROP || cnt == len_t'(MAX_LEN);
    wr_en = s_acc && !discard;
    push = wr_en && s_axis_tlast;
    drop = s_acc && discard && s_axis_tlast;
    wr_next = (s_acc && discard) ? (s_axis_tlast ? WR_FILL : WR_DROP) : wr_state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      wp_c <= '0;
      cnt <= '0;
      lf_wp <= '0;
      drop_pulse <= 1'b0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      drop_pulse <= drop;
      if (wr_en) begin
        wp <= wp + 1'b1;
        cnt <= push ? '0 : cnt + 1'b1;
      end
      if (push) begin
        wp_c <= wp + 1'b1;
        lf_wp <= lf_wp + 1'b1;
      end
      if (drop) begin
        wp <= wp_c;
        cnt <= '0;
      end
    end
  always_ff @(posedge clk)
    if (push) lf_mem[lf_wp[LW-1:0]] <= cnt + 1'b1;
  // On the last beat the next frame's length sits one entry past the head being popped.
  always_comb begin
    m_acc = m_axis_tvalid && m_axis_tready;
    pop = m_acc && rem == len_t'(1);
    more = frames_pending > lptr_t'(1);
    load = (rd_state == RD_IDLE && !lf_empty) || (pop && more);
    rd_en = load || (m_acc && !pop);
    head_idx = pop ? lf_rp[LW-1:0] + 1'b1 : lf_rp[LW-1:0];
    head_len = lf_mem[head_idx];
    rd_next = rd_state == RD_IDLE ? (lf_empty ? RD_IDLE : RD_LOAD)
            : rd_state == RD_LOAD ? RD_SEND
            : pop ? (more ? RD_LOAD : RD_IDLE) : RD_SEND;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rp <= '0;
      lf_rp <= '0;
      rem <= '0;
      m_axis_tuser <= '0;
    end else begin
      if (rd_en) rp <= rp + 1'b1;
      if (pop) lf_rp <= lf_rp + 1'b1;
      if (load) begin
        m_axis_tuser <= head_len;
        rem <= head_len;
      end else if (m_acc) rem <= rem - 1'b1;
    end
  sync_ram_1r1w #(.DEPTH(DEPTH), .W(8)) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .we(wr_en),
    .waddr(wp[AW-1:0]),
    .wdata(s_axis_tdata),
    .re(rd_en),
    .raddr(rp[AW-1:0]),
    .rdata(m_axis_tdata)
  );
endmodule

// File: tb/tb_axis_len_framer.sv
// tb_axis_len_framer: randomized frame traffic checked against a frame-queue reference model
module tb_axis_len_framer;
  localparam int MAX_LEN = 1472;
  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] s_axis_tdata, m_axis_tdata;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready, drop_pulse;
  logic [11:0] m_axis_tuser;
  logic [2:0] frames_pending;
  int errors = 0, checks = 0, cyc = 0, drops = 0, frames_out = 0, beat_idx = 0;
  int rise_cyc = 0, last_cyc = 0, sink_mode = 1;
  int exp_len [$];
  logic [7:0] exp_data [$];
  logic prev_v = 1'b0, stalled = 1'b0;
  logic [21:0] held = '0;

  axis_len_framer dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .drop_pulse(drop_pulse),
    .frames_pending(frames_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic summary;
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tuser"}, m_axis_tuser, 0);
    chk({tag, "_drop"}, drop_pulse, 0);
    chk({tag, "_pending"}, frames_pending, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
  endtask

  // Output monitor: every accepted beat is matched against the head of the expected frame queue.
  always @(negedge clk) begin
    if (drop_pulse) drops++;
    if (stalled && reset_n)
      chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
    if (m_axis_tvalid && !prev_v) rise_cyc = cyc;
    prev_v = m_axis_tvalid;
    stalled = m_axis_tvalid && !m_axis_tready;
    held = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_len.size() == 0) chk("spurious_beat", exp_len.size(), 1);
      else begin
        chk("tdata", m_axis_tdata, exp_data.pop_front());
        chk("tuser", m_axis_tuser, exp_len[0]);
        chk("tlast", m_axis_tlast, beat_idx == exp_len[0] - 1);
        if (beat_idx == exp_len[0] - 1) begin
          void'(exp_len.pop_front());
          beat_idx = 0;
          frames_out++;
        end else beat_idx++;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_axis_tready = sink_mode == 2 ? ($urandom_range(3) != 0) : (sink_mode == 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, limit reached");
    errors++;
    summary;
    $fatal(1);
  end

  task automatic put_byte(input logic [7:0] d, input logic last, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(3) == 0)
      repeat ($urandom_range(2, 1)) begin @(posedge clk); #1; end
    s_axis_tdata = d;
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 20000) begin @(negedge clk); n++; end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL s_tready_timeout: got 0 expected 1");
      summary;
      $fatal(1);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    if (last) last_cyc = cyc;
  endtask

  task automatic send_frame(input int len, input int kind, input bit gaps);
    logic [7:0] d [$];
    for (int i = 0; i < len; i++)
      d.push_back(kind == 0 ? 8'(i) : kind == 1 ? 8'hA5 : 8'($urandom));
    if (len <= MAX_LEN) begin
      exp_len.push_back(len);
      foreach (d[i]) exp_data.push_back(d[i]);
    end
    for (int i = 0; i < len; i++) put_byte(d[i], i == len - 1, gaps);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_len.size() != 0 || frames_pending != 0) && n < 50000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_drain"}, exp_len.size(), 0);
    chk({tag, "_pending"}, frames_pending, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tready_after_reset", s_axis_tready, 1);
    @(posedge clk);
    #1;
    send_frame(10, 0, 0);
    wait_drain("ramp10");
    chk("latency_ramp10", rise_cyc - last_cyc, 2);
    send_frame(1, 1, 0);
    wait_drain("one");
    chk("latency_one", rise_cyc - last_cyc, 2);
    n = drops;
    send_frame(MAX_LEN + 1, 2, 0);
    send_frame(4, 0, 0);
    wait_drain("oversize");
    chk("drop_count", drops - n, 1);
    chk("frames_after_drop", frames_out, 3);
    sink_mode = 0;
    repeat (4) send_frame(64, 2, 0);
    @(negedge clk);
    chk("bp_s_tready", s_axis_tready, 0);
    chk("bp_pending", frames_pending, 4);
    fork
      send_frame(64, 2, 0);
      begin repeat (10) @(posedge clk); sink_mode = 1; end
    join
    wait_drain("backpressure");
    chk("frames_after_bp", frames_out, 8);
    sink_mode = 2;
    for (int i = 0; i < 100; i++)
      send_frame(i == 0 ? MAX_LEN : i == 1 ? 1 :
                 ($urandom_range(9) == 0 ? $urandom_range(MAX_LEN, 1) : $urandom_range(64, 1)), 2, 1);
    wait_drain("random");
    chk("frames_after_random", frames_out, 108);
    chk("drops_total", drops, 1);
    sink_mode = 1;
    send_frame(300, 2, 0);
    for (int i = 0; i < 100; i++) put_byte(8'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    chk("streaming_before_reset", m_axis_tvalid, 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    exp_len.delete();
    exp_data.delete();
    beat_idx = 0;
    @(negedge clk);
    chk_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pending_after_reset", frames_pending, 0);
    chk("tvalid_after_reset", m_axis_tvalid, 0);
    chk("tready_after_mid_reset", s_axis_tready, 1);
    n = frames_out;
    @(posedge clk);
    #1;
    send_frame(8, 2, 0);
    wait_drain("post_reset");
    chk("frames_post_reset", frames_out - n, 1);
    summary;
    $finish;
  end
endmodule
